// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: deframer FSM states and
// the clock-per-bit timing arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Truncating division, so the sample point drifts slightly early on
  // non-integer clock/baud ratios.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int half_bit(input int clk_hz, input int baud);
    return (clk_hz / baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial line; 2-cycle latency, resets to idle-high.
// No backpressure: continuous sampling every clock.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with a one-entry holding register; byte offered 1 cycle after stop sample.
// Backpressure: a byte completing while the held byte is unaccepted is dropped with overrun_err.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mosi,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF         = half_bit(CLK_HZ, BAUD);
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);

  logic      rxs;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_done;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .dout (rxs)
  );

  // Counter always counts up to a terminal value and restarts at zero, so it
  // never has to pass through zero on the way down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == CNT_HALF_LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              byte_done <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // shreg is untouched until the next frame's first data sample, so it can
  // feed the holding register directly on the cycle after byte_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (byte_done) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_deframer.md
UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, asynchronous assert, active-high.
REQ-005 SHALL have port mosi  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  holding register full; byte offered downstream.
REQ-008 SHALL have port rx_ready  input  1  downstream (FIFO write side) accepts the byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-010 SHALL have port overrun_err  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL pass mosi through a 2-flop synchronizer before any use; synchronized line rxs lags mosi by 2 cycles.
REQ-012 SHALL use CLKS_PER_BIT = CLK_HZ/BAUD, truncated (5208 at defaults), and HALF = CLKS_PER_BIT/2 (2604).
REQ-013 SHALL run FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on rxs=0, SHALL clear the bit counter and enter START.
REQ-015 START: after HALF cycles, SHALL sample rxs; 0 -> DATA with counter reloaded to CLKS_PER_BIT; 1 -> IDLE (glitch reject, no output).
REQ-016 DATA: SHALL sample rxs every CLKS_PER_BIT cycles into bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, SHALL sample rxs; 1 -> byte complete, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL stay until rxs=1, then IDLE; no start detection meanwhile.
REQ-019 Byte complete SHALL load rx_data and set rx_valid on the next clock edge (1-cycle latency from stop sample).
REQ-020 Handshake: a transfer occurs on a cycle with rx_valid=1 and rx_ready=1; rx_valid SHALL clear the next cycle unless a new byte loads.
REQ-021 rx_data SHALL remain stable while rx_valid=1 and rx_ready=0.
REQ-022 Byte complete while rx_valid=1 and rx_ready=0: SHALL keep the held byte, drop the new one, pulse overrun_err.
REQ-023 Byte complete in the same cycle as a transfer: SHALL load the new byte, keep rx_valid=1, no overrun_err.
REQ-024 rx_ready SHALL be ignored while rx_valid=0; rx_valid SHALL NOT depend combinationally on rx_ready.
REQ-025 Bit counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap through zero unintentionally.

Reset
REQ-026 rst SHALL set FSM to IDLE, synchronizer flops to 1, counters to 0, rx_data to 0x00, rx_valid, frame_err and overrun_err to 0.
REQ-027 rst mid-frame SHALL abandon the partial byte with no output; after release the next start bit SHALL be received normally.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum and the CLKS_PER_BIT/HALF computation function.
REQ-029 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1); all other logic lives in uart_rx_deframer.

Verification
REQ-030 Send 0xA5 at 5200 clk/bit (104 us @ 50 MHz), rx_ready=1 -> one rx_valid pulse with rx_data=0xA5, no error pulses.
REQ-031 Drive mosi low for 1000 cycles then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-032 Send 0x3C with stop bit 0, line held low 20000 cycles, then high -> one frame_err pulse, no rx_valid; following 0x5A received correctly.
REQ-033 rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, one overrun_err pulse; raise rx_ready -> 0x11 transferred, rx_valid clears.
REQ-034 Hold 0x11, assert rx_ready exactly on the cycle 0x22 completes -> 0x11 transferred, rx_data=0x22 with rx_valid=1, no overrun_err.
REQ-035 Assert rst during bit 4 of 0xF0, release, send 0x0F -> only 0x0F delivered.
